// File: rtl/axil_uart_tx_slave.sv
// AXI4-Lite slave with a UART-Lite register map (RX/TX/STAT/CTRL)
// feeding a circular TX FIFO and a registered 8N1 serializer.
module axil_uart_tx_slave #(
  parameter int CLK_FREQ_HZ = 100000000,
  parameter int BAUD_RATE   = 115200,
  parameter int FIFO_DEPTH  = 16
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [3:0]  s_axi_awaddr_i,
  input  logic        s_axi_awvalid_i,
  output logic        s_axi_awready_o,
  input  logic [31:0] s_axi_wdata_i,
  input  logic [3:0]  s_axi_wstrb_i,
  input  logic        s_axi_wvalid_i,
  output logic        s_axi_wready_o,
  output logic [1:0]  s_axi_bresp_o,
  output logic        s_axi_bvalid_o,
  input  logic        s_axi_bready_i,
  input  logic [3:0]  s_axi_araddr_i,
  input  logic        s_axi_arvalid_i,
  output logic        s_axi_arready_o,
  output logic [31:0] s_axi_rdata_o,
  output logic [1:0]  s_axi_rresp_o,
  output logic        s_axi_rvalid_o,
  input  logic        s_axi_rready_i,
  output logic        tx_o
);

  localparam int CPB = CLK_FREQ_HZ / BAUD_RATE;
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int CW  = $clog2(CPB);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic          r_awready;
  logic          r_bvalid;
  logic [1:0]    r_bresp;
  logic          r_arready;
  logic          r_rvalid;
  logic [31:0]   r_rdata;

  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;

  logic [1:0]    r_state;
  logic [CW-1:0] r_clk_cnt;
  logic [2:0]    r_bit_idx;
  logic [7:0]    r_shift;
  logic          r_tx;

  logic          w_empty;
  logic          w_full;
  logic          w_busy;
  logic          w_tx_sel;
  logic          w_push;
  logic          w_drop;
  logic          w_flush;
  logic          w_pop;
  logic          w_bit_end;
  logic [31:0]   w_stat;
  logic [31:0]   w_rd_val;
  logic          w_unused;

  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == (AW+1)'(FIFO_DEPTH));
  assign w_busy    = (r_state != S_IDLE);
  assign w_tx_sel  = r_awready & (s_axi_awaddr_i[3:2] == 2'd1) & s_axi_wstrb_i[0];
  assign w_flush   = r_awready & (s_axi_awaddr_i[3:2] == 2'd3)
                   & s_axi_wstrb_i[0] & s_axi_wdata_i[0];
  assign w_push    = w_tx_sel & ~w_full & ~w_flush;
  assign w_drop    = w_tx_sel & w_full;
  assign w_pop     = (r_state == S_IDLE) & ~w_empty;
  assign w_bit_end = (r_clk_cnt == CW'(CPB - 1));
  assign w_stat    = {27'd0, w_busy, w_full, w_empty, 2'b00};
  assign w_rd_val  = (s_axi_araddr_i[3:2] == 2'd2) ? w_stat : 32'd0;
  assign w_unused  = &{1'b0, s_axi_awaddr_i[1:0], s_axi_araddr_i[1:0],
                       s_axi_wdata_i[31:8], s_axi_wstrb_i[3:1]};

  // Ready pulses one cycle after both valids seen; handshake completes on it.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_awready <= 1'b0;
      r_bvalid  <= 1'b0;
      r_bresp   <= 2'b00;
    end else begin
      r_awready <= s_axi_awvalid_i & s_axi_wvalid_i & ~r_bvalid & ~r_awready;
      if (r_awready) begin
        r_bvalid <= 1'b1;
        r_bresp  <= w_drop ? 2'b10 : 2'b00;
      end else if (r_bvalid & s_axi_bready_i) begin
        r_bvalid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rdata   <= 32'd0;
    end else begin
      r_arready <= s_axi_arvalid_i & ~r_rvalid & ~r_arready;
      if (r_arready) begin
        r_rvalid <= 1'b1;
        r_rdata  <= w_rd_val;
      end else if (r_rvalid & s_axi_rready_i) begin
        r_rvalid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wptr] <= s_axi_wdata_i[7:0];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (w_flush) begin
      r_rptr  <= r_wptr;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  end

  // Serializer: tx_o comes straight from a flop so the line never glitches.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state   <= S_IDLE;
      r_clk_cnt <= '0;
      r_bit_idx <= 3'd0;
      r_shift   <= 8'd0;
      r_tx      <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            r_state   <= S_START;
            r_shift   <= r_mem[r_rptr];
            r_clk_cnt <= '0;
            r_tx      <= 1'b0;
          end
        end
        S_START: begin
          if (w_bit_end) begin
            r_state   <= S_DATA;
            r_clk_cnt <= '0;
            r_bit_idx <= 3'd0;
            r_tx      <= r_shift[0];
          end else begin
            r_clk_cnt <= r_clk_cnt + CW'(1);
          end
        end
        S_DATA: begin
          if (w_bit_end) begin
            r_clk_cnt <= '0;
            if (r_bit_idx == 3'd7) begin
              r_state <= S_STOP;
              r_tx    <= 1'b1;
            end else begin
              r_bit_idx <= r_bit_idx + 3'd1;
              r_shift   <= {1'b0, r_shift[7:1]};
              r_tx      <= r_shift[1];
            end
          end else begin
            r_clk_cnt <= r_clk_cnt + CW'(1);
          end
        end
        default: begin
          if (w_bit_end) begin
            r_state   <= S_IDLE;
            r_clk_cnt <= '0;
          end else begin
            r_clk_cnt <= r_clk_cnt + CW'(1);
          end
        end
      endcase
    end
  end

  assign s_axi_awready_o = r_awready;
  assign s_axi_wready_o  = r_awready;
  assign s_axi_bvalid_o  = r_bvalid;
  assign s_axi_bresp_o   = r_bresp;
  assign s_axi_arready_o = r_arready;
  assign s_axi_rvalid_o  = r_rvalid;
  assign s_axi_rdata_o   = r_rdata;
  assign s_axi_rresp_o   = 2'b00;
  assign tx_o            = r_tx;

endmodule

// File: tb/tb_axil_uart_tx_slave.sv
// Directed bench: a fast instance (4 clocks/bit) and a slow one
// (1000 clocks/bit) share the bus inputs.
module tb_axil_uart_tx_slave;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  awaddr;
  logic        awvalid;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        bready;
  logic [3:0]  araddr;
  logic        arvalid;
  logic        rready;

  logic        awready, wready, bvalid, arready, rvalid, tx;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata;
  logic        s_awready, s_wready, s_bvalid, s_arready, s_rvalid, s_tx;
  logic [1:0]  s_bresp, s_rresp;
  logic [31:0] s_rdata;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  axil_uart_tx_slave #(
    .CLK_FREQ_HZ(4), .BAUD_RATE(1), .FIFO_DEPTH(16)
  ) u_fast (
    .clk_i(clk), .rst_ni(rst_n),
    .s_axi_awaddr_i(awaddr), .s_axi_awvalid_i(awvalid),
    .s_axi_awready_o(awready), .s_axi_wdata_i(wdata),
    .s_axi_wstrb_i(wstrb), .s_axi_wvalid_i(wvalid),
    .s_axi_wready_o(wready), .s_axi_bresp_o(bresp),
    .s_axi_bvalid_o(bvalid), .s_axi_bready_i(bready),
    .s_axi_araddr_i(araddr), .s_axi_arvalid_i(arvalid),
    .s_axi_arready_o(arready), .s_axi_rdata_o(rdata),
    .s_axi_rresp_o(rresp), .s_axi_rvalid_o(rvalid),
    .s_axi_rready_i(rready), .tx_o(tx)
  );

  axil_uart_tx_slave #(
    .CLK_FREQ_HZ(1000), .BAUD_RATE(1), .FIFO_DEPTH(16)
  ) u_slow (
    .clk_i(clk), .rst_ni(rst_n),
    .s_axi_awaddr_i(awaddr), .s_axi_awvalid_i(awvalid),
    .s_axi_awready_o(s_awready), .s_axi_wdata_i(wdata),
    .s_axi_wstrb_i(wstrb), .s_axi_wvalid_i(wvalid),
    .s_axi_wready_o(s_wready), .s_axi_bresp_o(s_bresp),
    .s_axi_bvalid_o(s_bvalid), .s_axi_bready_i(bready),
    .s_axi_araddr_i(araddr), .s_axi_arvalid_i(arvalid),
    .s_axi_arready_o(s_arready), .s_axi_rdata_o(s_rdata),
    .s_axi_rresp_o(s_rresp), .s_axi_rvalid_o(s_rvalid),
    .s_axi_rready_i(rready), .tx_o(s_tx)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) tick();
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0;
    wvalid = 1'b0; bready = 1'b1;
    araddr = '0; arvalid = 1'b0; rready = 1'b1;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic axi_write(input logic [3:0] a, input logic [31:0] d,
                           input logic [3:0] s,
                           output logic [1:0] rf, output logic [1:0] rs);
    int n = 0;
    awaddr = a; wdata = d; wstrb = s;
    awvalid = 1'b1; wvalid = 1'b1;
    do begin tick(); n++; end while (awready !== 1'b1 && n < 20);
    n_cmp++;
    if (!(awready === 1'b1 && wready === 1'b1)) begin
      n_err++;
      $display("FAIL wr_accept a=%h: aw=%b w=%b want 1 1", a, awready, wready);
    end
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    n_cmp++;
    if (bvalid !== 1'b1) begin
      n_err++;
      $display("FAIL wr_bvalid a=%h: got %b want 1", a, bvalid);
    end
    rf = bresp;
    rs = s_bresp;
  endtask

  task automatic axi_read(input logic [3:0] a,
                          output logic [31:0] df, output logic [31:0] ds);
    int n = 0;
    araddr = a; arvalid = 1'b1; rready = 1'b1;
    do begin tick(); n++; end while (arready !== 1'b1 && n < 20);
    tick();
    arvalid = 1'b0;
    n_cmp++;
    if (rvalid !== 1'b1) begin
      n_err++;
      $display("FAIL rd_rvalid a=%h: got %b want 1", a, rvalid);
    end
    df = rdata;
    ds = s_rdata;
  endtask

  task automatic find_start(input string nm, output int k);
    int n = 0;
    do begin tick(); n++; end while (tx !== 1'b0 && n < 20);
    k = cyc;
    n_cmp++;
    if (tx !== 1'b0) begin
      n_err++;
      $display("FAIL %s: tx got %b want 0 within 20 cycles", nm, tx);
    end
  endtask

  task automatic test_reset();
    logic [1:0] rf, rs;
    logic [31:0] df, ds;
    int k;
    apply_reset();
    n_cmp++;
    if (tx !== 1'b1) begin
      n_err++; $display("FAIL rst_tx: got %b want 1", tx);
    end
    n_cmp++;
    if ({awready, wready, bvalid, arready, rvalid} !== 5'b0) begin
      n_err++;
      $display("FAIL rst_valids: got %b want 00000",
               {awready, wready, bvalid, arready, rvalid});
    end
    n_cmp++;
    if ({bresp, rresp, rdata} !== 36'd0) begin
      n_err++;
      $display("FAIL rst_data: got %h want 0", {bresp, rresp, rdata});
    end
    axi_write(4'h4, 32'hA5, 4'h1, rf, rs);
    find_start("rst_frame_start", k);
    repeat (5) tick();
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({tx, bvalid, rvalid} !== 3'b100) begin
      n_err++;
      $display("FAIL rst_async: tx/bv/rv got %b want 100", {tx, bvalid, rvalid});
    end
    #3 rst_n = 1'b1;
    tick();
    axi_read(4'h8, df, ds);
    n_cmp++;
    if (df !== 32'h04) begin
      n_err++; $display("FAIL rst_stat: got %h want 00000004", df);
    end
  endtask

  task automatic test_tx_frame();
    logic [1:0] rf, rs;
    logic [9:0] frm;
    int k;
    apply_reset();
    frm = {1'b1, 8'h55, 1'b0};
    axi_write(4'h4, 32'h55, 4'h1, rf, rs);
    n_cmp++;
    if (rf !== 2'b00) begin
      n_err++; $display("FAIL tx_bresp: got %b want 00", rf);
    end
    find_start("tx_start", k);
    for (int i = 0; i < 10; i++) begin
      wait_until(k + 4 * i + 2);
      n_cmp++;
      if (tx !== frm[i]) begin
        n_err++; $display("FAIL tx_bit%0d: got %b want %b", i, tx, frm[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] rf, rs;
    int k, k2;
    apply_reset();
    axi_write(4'h4, 32'h00, 4'h1, rf, rs);
    find_start("b2b_start1", k);
    axi_write(4'h4, 32'h80, 4'h1, rf, rs);
    wait_until(k + 20);
    n_cmp++;
    if (tx !== 1'b0) begin
      n_err++; $display("FAIL b2b_mid: got %b want 0", tx);
    end
    wait_until(k + 36);
    find_start("b2b_start2", k2);
    n_cmp++;
    if (k2 !== k + 41) begin
      n_err++; $display("FAIL b2b_gap: start at %0d want %0d", k2, k + 41);
    end
    wait_until(k2 + 30);
    n_cmp++;
    if (tx !== 1'b0) begin
      n_err++; $display("FAIL b2b_bit6: got %b want 0", tx);
    end
    wait_until(k2 + 34);
    n_cmp++;
    if (tx !== 1'b1) begin
      n_err++; $display("FAIL b2b_bit7: got %b want 1", tx);
    end
  endtask

  task automatic test_fifo_full();
    logic [1:0] rf, rs;
    logic [31:0] df, ds;
    apply_reset();
    for (int i = 0; i < 18; i++) begin
      axi_write(4'h4, 32'(i + 1), 4'h1, rf, rs);
      n_cmp++;
      if (rs !== ((i == 17) ? 2'b10 : 2'b00)) begin
        n_err++; $display("FAIL full_bresp%0d: got %b", i, rs);
      end
    end
    axi_read(4'h8, df, ds);
    n_cmp++;
    if (ds !== 32'h18) begin
      n_err++; $display("FAIL full_stat: got %h want 00000018", ds);
    end
    n_cmp++;
    if (s_tx !== 1'b0) begin
      n_err++; $display("FAIL full_inflight: tx got %b want 0", s_tx);
    end
    axi_write(4'h4, 32'h99, 4'h0, rf, rs);
    n_cmp++;
    if (rs !== 2'b00) begin
      n_err++; $display("FAIL full_nostrb: got %b want 00", rs);
    end
    axi_write(4'hC, 32'h1, 4'h1, rf, rs);
    axi_read(4'h8, df, ds);
    n_cmp++;
    if (ds !== 32'h14) begin
      n_err++; $display("FAIL full_flush: got %h want 00000014", ds);
    end
  endtask

  task automatic test_regmap();
    logic [1:0] rf, rs;
    logic [31:0] df, ds;
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      logic [3:0] a;
      a = (i == 0) ? 4'h0 : (i == 1) ? 4'h4 : 4'hC;
      axi_read(a, df, ds);
      n_cmp++;
      if (df !== 32'd0) begin
        n_err++; $display("FAIL map_rd%h: got %h want 0", a, df);
      end
    end
    axi_write(4'h0, 32'hFF, 4'hF, rf, rs);
    n_cmp++;
    if (rf !== 2'b00) begin
      n_err++; $display("FAIL map_wr_rx: got %b want 00", rf);
    end
    axi_write(4'h8, 32'hFF, 4'hF, rf, rs);
    n_cmp++;
    if (rf !== 2'b00) begin
      n_err++; $display("FAIL map_wr_stat: got %b want 00", rf);
    end
    axi_read(4'h8, df, ds);
    n_cmp++;
    if (df !== 32'h04) begin
      n_err++; $display("FAIL map_stat: got %h want 00000004", df);
    end
  endtask

  task automatic test_split_handshake();
    int early = 0;
    int held_bad = 0;
    int n = 0;
    apply_reset();
    bready = 1'b0;
    awaddr = 4'h4; wdata = 32'h41; wstrb = 4'h1;
    awvalid = 1'b1;
    repeat (3) begin
      tick();
      if (awready !== 1'b0 || wready !== 1'b0) early++;
    end
    n_cmp++;
    if (early != 0) begin
      n_err++; $display("FAIL split_early: %0d ready cycles want 0", early);
    end
    wvalid = 1'b1;
    do begin tick(); n++; end while (awready !== 1'b1 && n < 10);
    n_cmp++;
    if (!(awready === 1'b1 && wready === 1'b1)) begin
      n_err++;
      $display("FAIL split_coincide: aw=%b w=%b want 1 1", awready, wready);
    end
    wdata = 32'h42;
    repeat (5) begin
      tick();
      if (bvalid !== 1'b1 || bresp !== 2'b00 || awready !== 1'b0) held_bad++;
    end
    n_cmp++;
    if (held_bad != 0) begin
      n_err++; $display("FAIL split_hold: %0d bad cycles want 0", held_bad);
    end
    bready = 1'b1;
    tick();
    n_cmp++;
    if (bvalid !== 1'b0) begin
      n_err++; $display("FAIL split_bclr: got %b want 0", bvalid);
    end
    n = 0;
    while (awready !== 1'b1 && n < 10) begin tick(); n++; end
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    n_cmp++;
    if (bvalid !== 1'b1) begin
      n_err++; $display("FAIL split_second: bvalid got %b want 1", bvalid);
    end
  endtask

  task automatic test_concurrent_read();
    logic [1:0] rf, rs;
    logic [31:0] d0, df, ds;
    int bad = 0;
    apply_reset();
    fork
      axi_write(4'h4, 32'h33, 4'h1, rf, rs);
      begin
        int n = 0;
        araddr = 4'h8; arvalid = 1'b1; rready = 1'b0;
        do begin tick(); n++; end while (arready !== 1'b1 && n < 20);
        tick();
        arvalid = 1'b0;
        d0 = rdata;
        if (rvalid !== 1'b1) bad++;
        repeat (4) begin
          tick();
          if (rvalid !== 1'b1 || rdata !== d0) bad++;
        end
        rready = 1'b1;
        tick();
        if (rvalid !== 1'b0) bad++;
      end
    join
    n_cmp++;
    if (bad != 0) begin
      n_err++; $display("FAIL conc_hold: %0d bad cycles want 0", bad);
    end
    n_cmp++;
    if (d0 !== 32'h04) begin
      n_err++; $display("FAIL conc_rdata: got %h want 00000004", d0);
    end
    n_cmp++;
    if (rf !== 2'b00) begin
      n_err++; $display("FAIL conc_bresp: got %b want 00", rf);
    end
    axi_read(4'h8, df, ds);
    n_cmp++;
    if (df !== 32'h14) begin
      n_err++; $display("FAIL conc_stat: got %h want 00000014", df);
    end
  endtask

  task automatic test_flush();
    logic [1:0] rf, rs;
    logic [31:0] df, ds;
    int k;
    int lows = 0;
    apply_reset();
    axi_write(4'h4, 32'h00, 4'h1, rf, rs);
    find_start("flush_start", k);
    for (int i = 1; i <= 5; i++)
      axi_write(4'h4, 32'(8'h11 * i), 4'h1, rf, rs);
    axi_write(4'hC, 32'h1, 4'h1, rf, rs);
    n_cmp++;
    if (rf !== 2'b00) begin
      n_err++; $display("FAIL flush_bresp: got %b want 00", rf);
    end
    axi_read(4'h8, df, ds);
    n_cmp++;
    if (df !== 32'h14) begin
      n_err++; $display("FAIL flush_stat_busy: got %h want 00000014", df);
    end
    wait_until(k + 30);
    n_cmp++;
    if (tx !== 1'b0) begin
      n_err++; $display("FAIL flush_inframe: got %b want 0", tx);
    end
    wait_until(k + 38);
    n_cmp++;
    if (tx !== 1'b1) begin
      n_err++; $display("FAIL flush_stop: got %b want 1", tx);
    end
    while (cyc < k + 120) begin
      tick();
      if (tx !== 1'b1) lows++;
    end
    n_cmp++;
    if (lows != 0) begin
      n_err++; $display("FAIL flush_idle: %0d low cycles want 0", lows);
    end
    axi_read(4'h8, df, ds);
    n_cmp++;
    if (df !== 32'h04) begin
      n_err++; $display("FAIL flush_stat: got %h want 00000004", df);
    end
  endtask

  initial begin
    test_reset();
    test_tx_frame();
    test_back_to_back();
    test_fifo_full();
    test_regmap();
    test_split_handshake();
    test_concurrent_read();
    test_flush();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
